decoder_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 3-to-8 and 6-to-64 one-hot decoders.
- Decodes NUM_CH independent ADDR_W-bit indices per transaction into 2^ADDR_W-bit masks. Mode is one-hot or thermometer.
- Output is registered behind a valid/ready handshake, with an OR-merged mask and same-target collision detection.
- Sits between decode/issue and the register-file write-enable and bank-select logic.

---
 rtl/cpu_dec_pkg.sv | 11 +
 rtl/dec_lane.sv | 32 +++
 rtl/decoder_pipe.sv | 153 +++++++++++++++
 tb/tb_decoder_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dec_pkg.sv
// Shared definitions for the decoder_pipe slice.
//   DEC_MODE_ONEHOT / DEC_MODE_THERMO : values carried on the in_mode / mode inputs
//   COLL_CNT_W                        : width of the optional collision counter
package cpu_dec_pkg;

    localparam logic DEC_MODE_ONEHOT = 1'b0;
    localparam logic DEC_MODE_THERMO = 1'b1;

    localparam int COLL_CNT_W = 16;

endpackage : cpu_dec_pkg

// File: rtl/dec_lane.sv
// Single-channel combinational decoder: ADDR_W-bit index -> OUT_W-bit mask.
//   addr : unsigned index, full range 0..OUT_W-1 is legal
//   en   : 0 forces the mask to all-zero
//   mode : DEC_MODE_ONEHOT sets bit addr only,
//          DEC_MODE_THERMO sets bits [addr:0]
//   mask : decoded result
module dec_lane
    import cpu_dec_pkg::*;
#(
    parameter  int ADDR_W = 6,
    localparam int OUT_W  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    input  logic              mode,
    output logic [OUT_W-1:0]  mask
);

    always_comb begin
        mask = '0;
        if (en) begin
            for (int i = 0; i < OUT_W; i++) begin
                if (mode == DEC_MODE_THERMO) begin
                    mask[i] = (i <= int'(addr));
                end else begin
                    mask[i] = (i == int'(addr));
                end
            end
        end
    end

endmodule : dec_lane

// File: rtl/decoder_pipe.sv
// Pipelined multi-channel index decoder with a registered valid/ready output.
//
// Decodes NUM_CH independent ADDR_W-bit indices into OUT_W-bit masks (one-hot
// or thermometer), registers them together with their OR-merge source and a
// same-target collision flag.
//
// Ports:
//   clk, rst_n    : rising-edge clock, synchronous active-low reset
//   in_valid      : input transaction valid
//   in_ready      : block can accept this cycle (combinational)
//   in_addr       : channel c index at [c*ADDR_W +: ADDR_W]
//   in_en         : per-channel enable, disabled channel decodes to zero
//   in_mode       : 0 = one-hot, 1 = thermometer
//   out_valid     : output register holds a transaction
//   out_ready     : consumer accepts this cycle
//   out_mask      : channel c mask at [c*OUT_W +: OUT_W]
//   out_or        : bitwise OR of all channel masks
//   out_collide   : one-hot mode, >=2 enabled channels share an index
//   coll_cnt      : saturating collision count (DEC_COLL_CNT_EN only)
//   coll_clr      : zero the collision count (DEC_COLL_CNT_EN only)
//
// Build option: define DEC_COLL_CNT_EN to add the collision counter and its
// two ports. Without it all other behaviour is unchanged.
//
// Handshake: a transaction moves on a clock edge where valid && ready are both
// high. in_ready = !out_valid || out_ready, so there is no skid buffer; while
// out_valid && !out_ready every output holds and no input is taken.
module decoder_pipe
    import cpu_dec_pkg::*;
#(
    parameter  int ADDR_W = 6,
    parameter  int NUM_CH = 2,
    localparam int OUT_W  = 2**ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef DEC_COLL_CNT_EN
    output logic [COLL_CNT_W-1:0]     coll_cnt,
    input  logic                      coll_clr,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*ADDR_W-1:0]  in_addr,
    input  logic [NUM_CH-1:0]         in_en,
    input  logic                      in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*OUT_W-1:0]   out_mask,
    output logic [OUT_W-1:0]          out_or,
    output logic                      out_collide
);

    logic [NUM_CH*OUT_W-1:0] lane_mask;
    logic                    hit;
    logic                    accept;

    logic                    valid_q,   valid_d;
    logic [NUM_CH*OUT_W-1:0] mask_q,    mask_d;
    logic                    collide_q, collide_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        dec_lane #(
            .ADDR_W (ADDR_W)
        ) u_lane (
            .addr (in_addr[c*ADDR_W +: ADDR_W]),
            .en   (in_en[c]),
            .mode (in_mode),
            .mask (lane_mask[c*OUT_W +: OUT_W])
        );
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Pairwise index compare over enabled channels; with NUM_CH=1 the loops are
    // empty and hit stays 0.
    always_comb begin
        hit = 1'b0;
        if (in_mode == DEC_MODE_ONEHOT) begin
            for (int a = 0; a < NUM_CH; a++) begin
                for (int b = a + 1; b < NUM_CH; b++) begin
                    if (in_en[a] && in_en[b] &&
                        (in_addr[a*ADDR_W +: ADDR_W] == in_addr[b*ADDR_W +: ADDR_W])) begin
                        hit = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        mask_d    = mask_q;
        collide_d = collide_q;
        if (accept) begin
            valid_d   = 1'b1;
            mask_d    = lane_mask;
            collide_d = hit;
        end else if (out_ready) begin
            // Drain: data keeps its last value, only valid drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            mask_q    <= '0;
            collide_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            mask_q    <= mask_d;
            collide_q <= collide_d;
        end
    end

    // OR-merge is taken from the registered masks so it always matches out_mask.
    always_comb begin
        out_or = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            out_or = out_or | mask_q[c*OUT_W +: OUT_W];
        end
    end

    assign out_valid   = valid_q;
    assign out_mask    = mask_q;
    assign out_collide = collide_q;

`ifdef DEC_COLL_CNT_EN
    logic [COLL_CNT_W-1:0] cnt_q, cnt_d;

    // Counts on the edge the colliding result is loaded; clear wins over count.
    always_comb begin
        cnt_d = cnt_q;
        if (coll_clr) begin
            cnt_d = '0;
        end else if (accept && hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + COLL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign coll_cnt = cnt_q;
`endif

endmodule : decoder_pipe

// File: tb/tb_decoder_pipe.sv
module tb_decoder_pipe;

  localparam int ADDR_W = 6;
  localparam int NUM_CH = 2;
  localparam int OUT_W  = 64;
  localparam int MW     = NUM_CH * OUT_W;
  localparam int EW     = MW + OUT_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*ADDR_W-1:0] in_addr;
  logic [NUM_CH-1:0]        in_en;
  logic                     in_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [MW-1:0]            out_mask;
  logic [OUT_W-1:0]         out_or;
  logic                     out_collide;
`ifdef DEC_COLL_CNT_EN
  logic [15:0]              coll_cnt;
  logic                     coll_clr;
  logic [15:0]              cnt_m;
`endif

  decoder_pipe #(
    .ADDR_W (ADDR_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef DEC_COLL_CNT_EN
    .coll_cnt    (coll_cnt),
    .coll_clr    (coll_clr),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_en       (in_en),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mask    (out_mask),
    .out_or      (out_or),
    .out_collide (out_collide)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  mon_en   = 0;
  bit  mv       = 0;   // model of "output register holds a transaction"
  bit  last_acc = 0;
  bit  rand_ready = 0;

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Reference: decode each channel arithmetically, count index hits per value.
  function automatic logic [EW-1:0] model(input logic [NUM_CH*ADDR_W-1:0] a,
                                          input logic [NUM_CH-1:0] en,
                                          input logic mode);
    logic [MW-1:0]    m;
    logic [OUT_W-1:0] o;
    logic [OUT_W:0]   w;
    logic [OUT_W:0]   one;
    int               hits[OUT_W];
    bit               col;
    int               idx;
    m = '0; o = '0; col = 0; one = 1;
    for (int i = 0; i < OUT_W; i++) hits[i] = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      idx = int'(a[c*ADDR_W +: ADDR_W]);
      if (en[c]) begin
        if (mode) w = (one << (idx + 1)) - one;
        else      w = one << idx;
        m[c*OUT_W +: OUT_W] = w[OUT_W-1:0];
        o = o | w[OUT_W-1:0];
        if (!mode) hits[idx] = hits[idx] + 1;
      end
    end
    for (int i = 0; i < OUT_W; i++) if (hits[i] >= 2) col = 1;
    return {col, o, m};
  endfunction

  // Issue side: push the expected response of every accepted transaction.
  always @(posedge clk) begin
    logic [EW-1:0] e;
    bit acc;
    if (!rst_n) begin
      mv = 0; last_acc = 0; exp_q.delete();
`ifdef DEC_COLL_CNT_EN
      cnt_m = 0;
`endif
    end else begin
      acc = in_valid && (!mv || out_ready);
      last_acc = acc;
      e = model(in_addr, in_en, in_mode);
      if (acc) exp_q.push_back(e);
`ifdef DEC_COLL_CNT_EN
      if (coll_clr) cnt_m = 0;
      else if (acc && e[EW-1] && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
      mv = acc || (mv && !out_ready);
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", EW'(out_valid), EW'(mv));
      check("in_ready", EW'(in_ready), EW'(!mv || out_ready));
      if (mv) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty got=output exp=none");
        end else begin
          check("out_data", {out_collide, out_or, out_mask}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
`ifdef DEC_COLL_CNT_EN
      check("coll_cnt", EW'(coll_cnt), EW'(cnt_m));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [1:0] en, input logic mode, input logic clr);
    in_addr  = {a1, a0};
    in_en    = en;
    in_mode  = mode;
    in_valid = 1'b1;
`ifdef DEC_COLL_CNT_EN
    coll_clr = clr;
`else
    if (clr) in_valid = 1'b1;
`endif
  endtask

  task automatic wait_acc(output int k);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end while (!last_acc && k < 200);
    if (!last_acc) begin
      n_checks++;
      $display("FAIL accept_timeout got=%0d exp=<200", k);
    end
    in_valid = 1'b0;
`ifdef DEC_COLL_CNT_EN
    coll_clr = 1'b0;
`endif
  endtask

  task automatic send(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input logic [1:0] en, input logic mode, input logic clr, output int k);
    drive(a0, a1, en, mode, clr);
    wait_acc(k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [ADDR_W-1:0] r0, r1;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_en = '0; in_mode = 1'b0; out_ready = 1'b1;
`ifdef DEC_COLL_CNT_EN
    coll_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", EW'(out_valid), EW'(0));
    check("rst_mask", EW'(out_mask), EW'(0));
    check("rst_or", EW'(out_or), EW'(0));
    check("rst_collide", EW'(out_collide), EW'(0));
    check("rst_ready", EW'(in_ready), EW'(1));
`ifdef DEC_COLL_CNT_EN
    check("rst_cnt", EW'(coll_cnt), EW'(0));
`endif
    rst_n = 1'b1;
    mon_en = 1;
    @(posedge clk); #1;

    // one-hot, ch1=5 ch0=63
    send(6'd63, 6'd5, 2'b11, 1'b0, 1'b0, k);
    check("oh_ch0", EW'(out_mask[63:0]), EW'(64'h8000000000000000));
    check("oh_ch1", EW'(out_mask[127:64]), EW'(64'h20));
    check("oh_or", EW'(out_or), EW'(64'h8000000000000020));
    check("oh_collide", EW'(out_collide), EW'(0));

    // thermometer boundaries
    send(6'd3, 6'd40, 2'b01, 1'b1, 1'b0, k);
    check("th3_ch0", EW'(out_mask[63:0]), EW'(64'hF));
    check("th3_ch1", EW'(out_mask[127:64]), EW'(0));
    check("th3_or", EW'(out_or), EW'(64'hF));
    send(6'd7, 6'd0, 2'b01, 1'b1, 1'b0, k);
    check("th7_ch0", EW'(out_mask[63:0]), EW'(64'hFF));
    send(6'd0, 6'd63, 2'b11, 1'b1, 1'b0, k);
    check("th0_ch0", EW'(out_mask[63:0]), EW'(64'h1));
    check("th63_ch1", EW'(out_mask[127:64]), EW'(64'hFFFFFFFFFFFFFFFF));

    // backpressure: A held for 3 cycles while B waits
    send(6'd1, 6'd2, 2'b11, 1'b0, 1'b0, k);
    out_ready = 1'b0;
    drive(6'd10, 6'd0, 2'b01, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_ready", EW'(in_ready), EW'(0));
      check("hold_or", EW'(out_or), EW'(64'h6));
    end
    out_ready = 1'b1;
    wait_acc(k);
    check("b_loaded_or", EW'(out_or), EW'(64'h400));

    // back-to-back: one accept per cycle
    for (int i = 0; i < 8; i++) begin
      send(6'(i * 7), 6'(i * 3 + 1), 2'b11, 1'(i & 1), 1'b0, k);
      check("b2b_latency", EW'(k), EW'(1));
    end

    // collision cases
    send(6'd9, 6'd9, 2'b11, 1'b0, 1'b0, k);
    check("coll_flag", EW'(out_collide), EW'(1));
    check("coll_or", EW'(out_or), EW'(64'h200));
    send(6'd9, 6'd9, 2'b01, 1'b0, 1'b0, k);
    check("coll_en01", EW'(out_collide), EW'(0));
    send(6'd9, 6'd9, 2'b11, 1'b1, 1'b0, k);
    check("coll_thermo", EW'(out_collide), EW'(0));

`ifdef DEC_COLL_CNT_EN
    send(6'd9, 6'd9, 2'b11, 1'b0, 1'b1, k);
    check("clr_beats_inc", EW'(coll_cnt), EW'(0));
    for (int i = 0; i < 65540; i++) send(6'd5, 6'd5, 2'b11, 1'b0, 1'b0, k);
    check("cnt_saturate", EW'(coll_cnt), EW'(16'hFFFF));
    send(6'd9, 6'd9, 2'b11, 1'b0, 1'b1, k);
    check("cnt_clr_coll", EW'(coll_cnt), EW'(0));
`endif

    // reset while holding: held data must vanish
    send(6'd20, 6'd21, 2'b11, 1'b0, 1'b0, k);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", EW'(out_valid), EW'(0));
    check("midrst_ready", EW'(in_ready), EW'(1));
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // randomized traffic with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      r0 = 6'($urandom_range(0, 63));
      r1 = ($urandom_range(0, 2) == 0) ? r0 : 6'($urandom_range(0, 63));
      send(r0, r1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), k);
    end
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", EW'(exp_q.size()), EW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_decoder_pipe
